// File: rtl/mole_hit_judge_pkg.sv
// Shared game-logic definitions for mole_hit_judge: FSM state
// encodings, tick counter width and the window shrink helper.
package mole_hit_judge_pkg;

    localparam int TICK_W = 8;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        UP   = 3'd2,
        GAP  = 3'd3,
        OVER = 3'd4
    } state_e;

    // Shrink by an eighth (at least one tick), clamped at the floor.
    function automatic logic [TICK_W-1:0] shrink_window(
        input logic [TICK_W-1:0] w,
        input logic [TICK_W-1:0] floor_w
    );
        logic [TICK_W-1:0] dec;
        logic [TICK_W-1:0] nw;
        dec = w >> 3;
        if (dec == '0) dec = TICK_W'(1);
        nw = (w > dec) ? w - dec : '0;
        if (nw < floor_w) nw = floor_w;
        return nw;
    endfunction

endpackage

// File: rtl/mole_hit_judge_tick_timer.sv
// tick_timer: counts tick pulses since the last load.
// Ports: clk, rst (async active-low), load, tick, limit -> done
// (done is high on the tick that finds count == limit-1).
module tick_timer
    import mole_hit_judge_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              tick,
    input  logic [TICK_W-1:0] limit,
    output logic              done
);

    logic [TICK_W-1:0] count_q;
    logic [TICK_W-1:0] count_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) count_q <= '0;
        else      count_q <= count_d;
    end

    always_comb begin
        count_d = count_q;
        if (load)      count_d = '0;
        else if (tick) count_d = count_q + TICK_W'(1);
    end

    assign done = tick && (count_q == limit - TICK_W'(1));

endmodule

// File: rtl/mole_hit_judge.sv
// mole_hit_judge: whack-a-mole judge. Requests mole positions, lights one
// LED, judges hit/wrong press/timeout, keeps score and lives.
// Ports: clk, rst (async active-low), tick, start, btn_pulse, mole_req/
// mole_ack/mole_pos handshake, led, score, lives, hit_pulse, miss_pulse,
// game_over. Define SPEEDUP_EN to shrink the window every 4th hit.
module mole_hit_judge
    import mole_hit_judge_pkg::*;
#(
    parameter int N_HOLES    = 4,
    parameter int POS_W      = 2,
    parameter int SCORE_W    = 8,
    parameter int LIVES      = 3,
    parameter int WINDOW     = 20,
    parameter int GAP_TICKS  = 4,
    parameter int MIN_WINDOW = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick,
    input  logic               start,
    input  logic [N_HOLES-1:0] btn_pulse,
    output logic               mole_req,
    input  logic               mole_ack,
    input  logic [POS_W-1:0]   mole_pos,
    output logic [N_HOLES-1:0] led,
    output logic [SCORE_W-1:0] score,
    output logic [2:0]         lives,
    output logic               hit_pulse,
    output logic               miss_pulse,
    output logic               game_over
);

    localparam logic [N_HOLES-1:0] LED_ONE = N_HOLES'(1);

    state_e             state_q, state_d;
    logic [N_HOLES-1:0] led_q, led_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [2:0]         lives_q, lives_d;
    logic               req_q, req_d;
    logic               hit_q, hit_d;
    logic               miss_q, miss_d;
    logic               over_q, over_d;
    logic [TICK_W-1:0]  window;
    logic [TICK_W-1:0]  limit;
    logic               load;
    logic               done;
    logic               new_game;

`ifdef SPEEDUP_EN
    logic [TICK_W-1:0]  window_q, window_d;
    logic [1:0]         hits_q, hits_d;
    assign window = window_q;
`else
    assign window = TICK_W'(WINDOW);
`endif

    // Counter restarts whenever the state changes or is idle/waiting.
    assign load  = (state_d != state_q) ||
                   (state_q != UP && state_q != GAP);
    assign limit = (state_q == UP) ? window : TICK_W'(GAP_TICKS);

    tick_timer u_timer (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .tick  (tick),
        .limit (limit),
        .done  (done)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            led_q    <= '0;
            score_q  <= '0;
            lives_q  <= 3'(LIVES);
            req_q    <= 1'b0;
            hit_q    <= 1'b0;
            miss_q   <= 1'b0;
            over_q   <= 1'b0;
`ifdef SPEEDUP_EN
            window_q <= TICK_W'(WINDOW);
            hits_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            led_q    <= led_d;
            score_q  <= score_d;
            lives_q  <= lives_d;
            req_q    <= req_d;
            hit_q    <= hit_d;
            miss_q   <= miss_d;
            over_q   <= over_d;
`ifdef SPEEDUP_EN
            window_q <= window_d;
            hits_q   <= hits_d;
`endif
        end
    end

    assign new_game = start && (state_q == IDLE || state_q == OVER);

    always_comb begin
        state_d = state_q;
        led_d   = led_q;
        score_d = score_q;
        lives_d = lives_q;
        req_d   = req_q;
        hit_d   = 1'b0;
        miss_d  = 1'b0;
        over_d  = over_q;
`ifdef SPEEDUP_EN
        window_d = window_q;
        hits_d   = hits_q;
`endif
        unique case (state_q)
            IDLE, OVER: begin
                led_d = '0;
                if (new_game) begin
                    state_d = REQ;
                    score_d = '0;
                    lives_d = 3'(LIVES);
                    req_d   = 1'b1;
                    over_d  = 1'b0;
`ifdef SPEEDUP_EN
                    window_d = TICK_W'(WINDOW);
                    hits_d   = '0;
`endif
                end
            end
            REQ: begin
                req_d = 1'b1;
                // Out-of-range positions are dropped; keep requesting.
                if (req_q && mole_ack && int'(mole_pos) < N_HOLES) begin
                    state_d = UP;
                    led_d   = LED_ONE << mole_pos;
                    req_d   = 1'b0;
                end
            end
            UP: begin
                // A press takes priority over a coincident timeout tick.
                if (btn_pulse == led_q) begin
                    state_d = GAP;
                    led_d   = '0;
                    hit_d   = 1'b1;
                    if (score_q != '1) score_d = score_q + SCORE_W'(1);
`ifdef SPEEDUP_EN
                    hits_d = hits_q + 2'd1;
                    if (hits_q == 2'd3)
                        window_d = shrink_window(window_q,
                                                 TICK_W'(MIN_WINDOW));
`endif
                end else if (btn_pulse != '0 || done) begin
                    led_d   = '0;
                    miss_d  = 1'b1;
                    lives_d = lives_q - 3'd1;
                    if (lives_q == 3'd1) begin
                        state_d = OVER;
                        over_d  = 1'b1;
                    end else begin
                        state_d = GAP;
                    end
                end
            end
            GAP: begin
                if (done) begin
                    state_d = REQ;
                    req_d   = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                led_d   = '0;
                req_d   = 1'b0;
            end
        endcase
    end

    always_comb begin
        mole_req   = req_q;
        led        = led_q;
        score      = score_q;
        lives      = lives_q;
        hit_pulse  = hit_q;
        miss_pulse = miss_q;
        game_over  = over_q;
    end

endmodule

// File: tb/tb_mole_hit_judge.sv
// Scoreboarded directed bench for mole_hit_judge.
// Expected hit/miss events are queued; a monitor checks each pulse.
module tb_mole_hit_judge;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tick = 1'b0;
    logic       start = 1'b0;
    logic [3:0] btn_pulse = '0;
    logic       mole_req;
    logic       mole_ack = 1'b0;
    logic [2:0] mole_pos = '0;
    logic [3:0] led;
    logic [7:0] score;
    logic [2:0] lives;
    logic       hit_pulse;
    logic       miss_pulse;
    logic       game_over;

    typedef struct {
        bit is_hit;
        int score;
        int lives;
        bit over;
    } ev_t;

    ev_t sb[$];
    ev_t mon_e;
    int  n_checks = 0;
    int  n_fail = 0;
    int  exp_score = 0;
    int  exp_lives = 3;

`ifdef SPEEDUP_EN
    localparam int EXP_WIN8 = 16;
`else
    localparam int EXP_WIN8 = 20;
`endif

    mole_hit_judge #(.POS_W(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick),
        .start      (start),
        .btn_pulse  (btn_pulse),
        .mole_req   (mole_req),
        .mole_ack   (mole_ack),
        .mole_pos   (mole_pos),
        .led        (led),
        .score      (score),
        .lives      (lives),
        .hit_pulse  (hit_pulse),
        .miss_pulse (miss_pulse),
        .game_over  (game_over)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst && (hit_pulse || miss_pulse)) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_pulse: hit=%0d miss=%0d expected none",
                         hit_pulse, miss_pulse);
            end else begin
                mon_e = sb.pop_front();
                chk("ev_hit", int'(hit_pulse), int'(mon_e.is_hit));
                chk("ev_miss", int'(miss_pulse), int'(!mon_e.is_hit));
                chk("ev_score", int'(score), mon_e.score);
                chk("ev_lives", int'(lives), mon_e.lives);
                chk("ev_over", int'(game_over), int'(mon_e.over));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_hit();
        exp_score++;
        sb.push_back('{1'b1, exp_score, exp_lives, 1'b0});
    endtask

    task automatic exp_miss();
        exp_lives--;
        sb.push_back('{1'b0, exp_score, exp_lives, exp_lives == 0});
    endtask

    task automatic press(input logic [3:0] b);
        btn_pulse = b;
        step();
        btn_pulse = '0;
    endtask

    task automatic ticks(input int n);
        tick = 1'b1;
        repeat (n) step();
        tick = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
        exp_score = 0;
        exp_lives = 3;
    endtask

    task automatic give_mole(input logic [2:0] pos);
        int k;
        k = 0;
        while (!mole_req && k < 200) begin
            step();
            k++;
        end
        if (!mole_req) chk("mole_req_wait", 0, 1);
        mole_ack = 1'b1;
        mole_pos = pos;
        step();
        mole_ack = 1'b0;
    endtask

    task automatic chk_reset(input string nm);
        chk({nm, "_led"}, int'(led), 0);
        chk({nm, "_score"}, int'(score), 0);
        chk({nm, "_lives"}, int'(lives), 3);
        chk({nm, "_req"}, int'(mole_req), 0);
        chk({nm, "_hit"}, int'(hit_pulse), 0);
        chk({nm, "_miss"}, int'(miss_pulse), 0);
        chk({nm, "_over"}, int'(game_over), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation still running, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] b;
        step();
        chk_reset("reset");
        rst = 1'b1;
        step();
        // idle ignores presses and ticks
        press(4'b0001);
        ticks(3);
        chk("idle_score", int'(score), 0);
        chk("idle_req", int'(mole_req), 0);

        // 1: hit
        do_start();
        chk("start_req", int'(mole_req), 1);
        give_mole(3'd2);
        chk("up_led", int'(led), 4'b0100);
        chk("up_req", int'(mole_req), 0);
        exp_hit();
        press(4'b0100);
        chk("hit_led", int'(led), 0);
        chk("hit_score", int'(score), 1);
        press(4'b0001);
        ticks(4);

        // 2: timeout
        give_mole(3'd1);
        ticks(19);
        chk("pre_to_led", int'(led), 4'b0010);
        exp_miss();
        ticks(1);
        chk("to_led", int'(led), 0);
        chk("to_lives", int'(lives), 2);
        ticks(4);

        // 3: wrong presses to game over
        give_mole(3'd0);
        exp_miss();
        press(4'b0011);
        ticks(4);
        give_mole(3'd3);
        exp_miss();
        press(4'b0100);
        chk("over_flag", int'(game_over), 1);
        chk("over_score", int'(score), 1);
        chk("over_led", int'(led), 0);
        ticks(5);
        press(4'b0001);
        chk("over_hold", int'(lives), 0);
        do_start();
        chk("restart_score", int'(score), 0);
        chk("restart_lives", int'(lives), 3);
        chk("restart_over", int'(game_over), 0);

        // 4: out-of-range position
        give_mole(3'd5);
        chk("bad_pos_led", int'(led), 0);
        chk("bad_pos_req", int'(mole_req), 1);
        give_mole(3'd3);
        chk("pos3_led", int'(led), 4'b1000);

        // 5: press on final tick, then reset mid-UP
        ticks(19);
        exp_hit();
        tick = 1'b1;
        btn_pulse = 4'b1000;
        step();
        tick = 1'b0;
        btn_pulse = '0;
        chk("tie_score", int'(score), 1);
        chk("tie_lives", int'(lives), 3);
        ticks(4);
        give_mole(3'd2);
        chk("pre_rst_led", int'(led), 4'b0100);
        rst = 1'b0;
        #1;
        chk_reset("mid_rst");
        step();
        rst = 1'b1;
        step();

        // 6: eight hits, then window timeout
        do_start();
        for (int i = 0; i < 8; i++) begin
            give_mole(3'(i % 4));
            b = 4'b0001 << (i % 4);
            exp_hit();
            press(b);
            ticks(4);
        end
        chk("eight_score", int'(score), 8);
        give_mole(3'd1);
        ticks(EXP_WIN8 - 1);
        chk("win_pre_led", int'(led), 4'b0010);
        exp_miss();
        ticks(1);
        chk("win_led", int'(led), 0);
        chk("win_lives", int'(lives), 2);

        repeat (3) step();
        chk("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
